// File: rtl/fifo_pkg.sv
// Gray/binary helpers and default geometry shared by the async FIFO
// write-side and read-side pointer blocks.
package fifo_pkg;

   localparam int unsigned FIFO_SIZE = 4;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; callers truncate to their pointer width
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int unsigned i = 31; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

endpackage

// File: rtl/write_ptr_ctrl_if.sv
// Write-side bus of the async FIFO: request/clear inputs, synced read pointer,
// RAM write port and status flags.
interface write_ptr_ctrl_if
   import fifo_pkg::*;
#(
   parameter int unsigned SIZE = FIFO_SIZE
);
   logic            winc;
   logic [SIZE:0]   wq2_rptr;
   logic            wovf_clr;
   logic            wen;
   logic [SIZE-1:0] waddr;
   logic [SIZE:0]   wptr;
   logic            wfull;
   logic            walmost_full;
   logic [SIZE:0]   wlevel;
   logic            woverflow;

   modport master (
      output winc, wq2_rptr, wovf_clr,
      input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
   );

   modport slave (
      input  winc, wq2_rptr, wovf_clr,
      output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
   );
endinterface

// File: rtl/write_ptr_ctrl.sv
// Write-domain pointer/flag controller of the async FIFO: binary and Gray
// write pointers, RAM write port, and pessimistic full/level/overflow flags.
module write_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned SIZE         = FIFO_SIZE,
   parameter int unsigned AFULL_THRESH = 14
) (
   input  logic            wclk,
   input  logic            wrst_n,
   write_ptr_ctrl_if.slave wif
);
   localparam int unsigned PW = SIZE + 1;

   logic [SIZE:0] wbin_q, wbin_d;
   logic [SIZE:0] wptr_q, wptr_d;
   logic [SIZE:0] wlevel_q, wlevel_d;
   logic [SIZE:0] rbin_s;
   logic          wfull_q, wfull_d;
   logic          wafull_q, wafull_d;
   logic          wovf_q, wovf_d;
   logic          wen;

   always_comb begin
      wen      = wif.winc & ~wfull_q;
      wbin_d   = wbin_q + {{SIZE{1'b0}}, wen};
      wptr_d   = PW'(bin2gray(32'(wbin_d)));
      rbin_s   = PW'(gray2bin(32'(wif.wq2_rptr)));
      // Full when the write pointer is one lap ahead: top two Gray bits inverted
      wfull_d  = (wptr_d == {~wif.wq2_rptr[SIZE:SIZE-1], wif.wq2_rptr[SIZE-2:0]});
      wlevel_d = wbin_d - rbin_s;
      wafull_d = (32'(wlevel_d) >= AFULL_THRESH);
      // A new overflow in the same cycle as a clear keeps the flag set
      wovf_d   = (wif.winc & wfull_q) | (wovf_q & ~wif.wovf_clr);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q <= '0;
         wptr_q <= '0;
      end else begin
         wbin_q <= wbin_d;
         wptr_q <= wptr_d;
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wlevel_q <= '0;
         wovf_q   <= 1'b0;
      end else begin
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wlevel_q <= wlevel_d;
         wovf_q   <= wovf_d;
      end
   end

   assign wif.wen          = wen;
   assign wif.waddr        = wbin_q[SIZE-1:0];
   assign wif.wptr         = wptr_q;
   assign wif.wfull        = wfull_q;
   assign wif.walmost_full = wafull_q;
   assign wif.wlevel       = wlevel_q;
   assign wif.woverflow    = wovf_q;

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Directed bench for write_ptr_ctrl (SIZE=4, AFULL_THRESH=14): vector table for
// fill/overflow/drain plus hand sequences for reset and pointer wrap.
module tb_write_ptr_ctrl;

   typedef struct {
      logic       winc;
      logic       clr;
      logic [4:0] rptr;
      logic       exp_wen;
      logic [4:0] exp_wptr;
      logic [3:0] exp_waddr;
      logic [4:0] exp_lvl;
      logic       exp_full;
      logic       exp_afull;
      logic       exp_ovf;
   } vec_t;

   logic wclk   = 1'b0;
   logic wrst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   vec_t vecs[30];

   always #5 wclk = ~wclk;

   write_ptr_ctrl_if #(.SIZE(4)) wif ();

   write_ptr_ctrl #(.SIZE(4), .AFULL_THRESH(14)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .wif    (wif.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".wptr"},   32'(wif.wptr), 0);
      chk({tag, ".waddr"},  32'(wif.waddr), 0);
      chk({tag, ".wlevel"}, 32'(wif.wlevel), 0);
      chk({tag, ".wfull"},  32'(wif.wfull), 0);
      chk({tag, ".wafull"}, 32'(wif.walmost_full), 0);
      chk({tag, ".wovf"},   32'(wif.woverflow), 0);
   endtask

   function automatic vec_t mk(logic winc, logic clr, logic [4:0] rptr, logic wen,
                               logic [4:0] wptr, logic [3:0] waddr, logic [4:0] lvl,
                               logic full, logic afull, logic ovf);
      vec_t v;
      v.winc = winc; v.clr = clr; v.rptr = rptr; v.exp_wen = wen;
      v.exp_wptr = wptr; v.exp_waddr = waddr; v.exp_lvl = lvl;
      v.exp_full = full; v.exp_afull = afull; v.exp_ovf = ovf;
      return v;
   endfunction

   function automatic logic [4:0] gray5(int n);
      logic [4:0] b;
      b = 5'(n);
      return b ^ (b >> 1);
   endfunction

   initial begin
      logic [4:0] prev_wptr;
      logic [4:0] diff;
      int         ones;
      int         lvl_exp;

      //           winc clr rptr     wen wptr      waddr lvl  full afull ovf
      vecs[0]  = mk(1, 0, 5'b00000, 1, 5'b00001, 4'd1,  5'd1,  0, 0, 0);
      vecs[1]  = mk(1, 0, 5'b00000, 1, 5'b00011, 4'd2,  5'd2,  0, 0, 0);
      vecs[2]  = mk(1, 0, 5'b00000, 1, 5'b00010, 4'd3,  5'd3,  0, 0, 0);
      vecs[3]  = mk(1, 0, 5'b00000, 1, 5'b00110, 4'd4,  5'd4,  0, 0, 0);
      vecs[4]  = mk(1, 0, 5'b00000, 1, 5'b00111, 4'd5,  5'd5,  0, 0, 0);
      vecs[5]  = mk(1, 0, 5'b00000, 1, 5'b00101, 4'd6,  5'd6,  0, 0, 0);
      vecs[6]  = mk(1, 0, 5'b00000, 1, 5'b00100, 4'd7,  5'd7,  0, 0, 0);
      vecs[7]  = mk(1, 0, 5'b00000, 1, 5'b01100, 4'd8,  5'd8,  0, 0, 0);
      vecs[8]  = mk(1, 0, 5'b00000, 1, 5'b01101, 4'd9,  5'd9,  0, 0, 0);
      vecs[9]  = mk(1, 0, 5'b00000, 1, 5'b01111, 4'd10, 5'd10, 0, 0, 0);
      vecs[10] = mk(1, 0, 5'b00000, 1, 5'b01110, 4'd11, 5'd11, 0, 0, 0);
      vecs[11] = mk(1, 0, 5'b00000, 1, 5'b01010, 4'd12, 5'd12, 0, 0, 0);
      vecs[12] = mk(1, 0, 5'b00000, 1, 5'b01011, 4'd13, 5'd13, 0, 0, 0);
      vecs[13] = mk(1, 0, 5'b00000, 1, 5'b01001, 4'd14, 5'd14, 0, 1, 0);
      vecs[14] = mk(1, 0, 5'b00000, 1, 5'b01000, 4'd15, 5'd15, 0, 1, 0);
      vecs[15] = mk(1, 0, 5'b00000, 1, 5'b11000, 4'd0,  5'd16, 1, 1, 0);
      vecs[16] = mk(1, 0, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 1);
      vecs[17] = mk(1, 0, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 1);
      vecs[18] = mk(1, 0, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 1);
      vecs[19] = mk(0, 1, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 0);
      vecs[20] = mk(1, 1, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 1);
      vecs[21] = mk(0, 0, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 1);
      vecs[22] = mk(0, 1, 5'b00000, 0, 5'b11000, 4'd0,  5'd16, 1, 1, 0);
      vecs[23] = mk(0, 0, 5'b00110, 0, 5'b11000, 4'd0,  5'd12, 0, 0, 0);
      vecs[24] = mk(1, 0, 5'b00110, 1, 5'b11001, 4'd1,  5'd13, 0, 0, 0);
      vecs[25] = mk(1, 0, 5'b00110, 1, 5'b11011, 4'd2,  5'd14, 0, 1, 0);
      vecs[26] = mk(1, 0, 5'b00110, 1, 5'b11010, 4'd3,  5'd15, 0, 1, 0);
      vecs[27] = mk(1, 0, 5'b00110, 1, 5'b11110, 4'd4,  5'd16, 1, 1, 0);
      vecs[28] = mk(1, 0, 5'b00111, 0, 5'b11110, 4'd4,  5'd15, 0, 1, 1);
      vecs[29] = mk(0, 1, 5'b00111, 0, 5'b11110, 4'd4,  5'd15, 0, 1, 0);

      // Reset held while winc toggles across edges
      wif.winc = 1'b0; wif.wovf_clr = 1'b0; wif.wq2_rptr = '0;
      @(posedge wclk); #1;
      for (int i = 0; i < 4; i++) begin
         wif.winc = ~wif.winc;
         @(posedge wclk); #1;
         chk_all_zero("reset_hold");
      end
      wif.winc = 1'b0; #1;
      chk("reset_wen", 32'(wif.wen), 0);
      wrst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         wif.winc = vecs[i].winc; wif.wovf_clr = vecs[i].clr; wif.wq2_rptr = vecs[i].rptr;
         #1;
         chk($sformatf("v%0d.wen", i), 32'(wif.wen), 32'(vecs[i].exp_wen));
         @(posedge wclk); #1;
         chk($sformatf("v%0d.wptr", i),   32'(wif.wptr),         32'(vecs[i].exp_wptr));
         chk($sformatf("v%0d.waddr", i),  32'(wif.waddr),        32'(vecs[i].exp_waddr));
         chk($sformatf("v%0d.wlevel", i), 32'(wif.wlevel),       32'(vecs[i].exp_lvl));
         chk($sformatf("v%0d.wfull", i),  32'(wif.wfull),        32'(vecs[i].exp_full));
         chk($sformatf("v%0d.wafull", i), 32'(wif.walmost_full), 32'(vecs[i].exp_afull));
         chk($sformatf("v%0d.wovf", i),   32'(wif.woverflow),    32'(vecs[i].exp_ovf));
      end

      // Mid-burst async reset: outputs must clear without a clock edge
      wif.wovf_clr = 1'b0; wif.winc = 1'b1;
      @(posedge wclk); #1;
      chk("burst_wlevel", 32'(wif.wlevel), 16);
      chk("burst_wfull",  32'(wif.wfull), 1);
      wif.winc = 1'b1;
      @(posedge wclk); #1;
      chk("burst_wovf", 32'(wif.woverflow), 1);
      #2 wrst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      wif.winc = 1'b0; wif.wq2_rptr = '0;
      @(posedge wclk); #1;
      chk_all_zero("async_reset_edge");
      wrst_n = 1'b1;

      // 100 writes with the read pointer trailing by three writes
      prev_wptr = '0;
      for (int k = 1; k <= 100; k++) begin
         wif.winc = 1'b1;
         wif.wq2_rptr = (k >= 3) ? gray5(k - 3) : 5'b00000;
         @(posedge wclk); #1;
         lvl_exp = (k < 3) ? k : 3;
         chk($sformatf("wrap%0d.wptr", k),   32'(wif.wptr), 32'(gray5(k)));
         chk($sformatf("wrap%0d.waddr", k),  32'(wif.waddr), 32'(k % 16));
         chk($sformatf("wrap%0d.wlevel", k), 32'(wif.wlevel), 32'(lvl_exp));
         chk($sformatf("wrap%0d.wfull", k),  32'(wif.wfull), 0);
         diff = wif.wptr ^ prev_wptr;
         ones = 0;
         for (int b = 0; b < 5; b++) ones += int'(diff[b]);
         chk($sformatf("wrap%0d.onebit", k), 32'(ones), 1);
         prev_wptr = wif.wptr;
      end
      wif.winc = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
